// File: rtl/hilo_unit.sv
// HI/LO register unit behind the EX-stage multiplier: commits products as
// plain writes or 64-bit accumulates, services MTHI/MTLO/MFHI/MFLO, raises hazard_stall.
module hilo_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              mul_issue,
    input  logic [1:0]        mul_mode,
    input  logic              mul_ce,
    input  logic [DATA_W-1:0] mul_hi,
    input  logic [DATA_W-1:0] mul_lo,
    input  logic              mt_we,
    input  logic              mt_sel,
    input  logic [DATA_W-1:0] mt_data,
    input  logic              mf_req,
    input  logic              mf_sel,
    output logic [DATA_W-1:0] mf_data,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              hazard_stall
);

    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PEND = 2'b01,
        ACC  = 2'b10
    } state_t;

    localparam logic [1:0] MODE_WR  = 2'b00;
    localparam logic [1:0] MODE_ADD = 2'b01;
    localparam logic [1:0] MODE_SUB = 2'b10;

    // The reserved encoding collapses to a plain write so ACC only ever sees add/sub.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        case (m)
            MODE_ADD: return MODE_ADD;
            MODE_SUB: return MODE_SUB;
            default:  return MODE_WR;
        endcase
    endfunction

    state_t              state_r, state_s;
    logic [1:0]          mode_r, mode_s;
    logic [PROD_W-1:0]   prod_r, prod_s;
    logic [DATA_W-1:0]   hi_r, hi_s;
    logic [DATA_W-1:0]   lo_r, lo_s;
    logic                accept_s;
    logic                busy_s;
    logic [PROD_W-1:0]   acc_sum_s;
    logic [PROD_W-1:0]   acc_dif_s;

    assign accept_s  = ~stall & ~flush;
    assign busy_s    = (state_r != IDLE);
    assign acc_sum_s = {hi_r, lo_r} + prod_r;
    assign acc_dif_s = {hi_r, lo_r} - prod_r;

    // Next-state, pending mode, product capture and HI/LO update.
    always_comb begin
        state_s = state_r;
        mode_s  = mode_r;
        prod_s  = prod_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        case (state_r)
            IDLE: begin
                if (mul_issue && accept_s) begin
                    state_s = PEND;
                    mode_s  = norm_mode(mul_mode);
                end else if (mt_we && accept_s) begin
                    if (mt_sel) begin
                        hi_s = mt_data;
                    end else begin
                        lo_s = mt_data;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            PEND: begin
                // flush outranks a same-cycle result strobe; stall never holds us here
                if (flush) begin
                    state_s = IDLE;
                end else if (mul_ce) begin
                    if (mode_r == MODE_WR) begin
                        hi_s    = mul_hi;
                        lo_s    = mul_lo;
                        state_s = IDLE;
                    end else begin
                        prod_s  = {mul_hi, mul_lo};
                        state_s = ACC;
                    end
                end else begin
                    state_s = PEND;
                end
            end
            ACC: begin
                if (flush) begin
                    state_s = IDLE;
                end else if (mode_r == MODE_SUB) begin
                    {hi_s, lo_s} = acc_dif_s;
                    state_s      = IDLE;
                end else begin
                    {hi_s, lo_s} = acc_sum_s;
                    state_s      = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and architectural registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            mode_r  <= 2'b00;
            prod_r  <= {PROD_W{1'b0}};
            hi_r    <= {DATA_W{1'b0}};
            lo_r    <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_s;
            mode_r  <= mode_s;
            prod_r  <= prod_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
        end
    end

    assign hi           = hi_r;
    assign lo           = lo_r;
    assign busy         = busy_s;
    assign mf_data      = mf_sel ? hi_r : lo_r;
    assign hazard_stall = busy_s & (mul_issue | mt_we | mf_req);

endmodule
